// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wb_port_arbiter_pkg
//  Purpose : Shared types and constants for the register-file write-port
//            arbiter and its MDU result FIFO.
//  Contents: REG_W/DATA_W/ENT_W widths, occupancy-state encoding occ_e,
//            write-source constants SRC_PIPE/SRC_MDU.
//  Revision: 1.0  initial release
// ============================================================================
package wb_port_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   // One buffered MDU result: {destination register, data}
   localparam int ENT_W  = REG_W + DATA_W;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   localparam logic SRC_PIPE = 1'b0;
   localparam logic SRC_MDU  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : wb_result_fifo
//  Purpose : 2-entry in-order FIFO holding MDU results waiting for the
//            register-file write port.
//  Ports   : clk, rst (async active-low)
//            i_push / i_push_data : enqueue one {dest,data} entry
//            i_pop                : dequeue the head entry
//            o_head               : current head entry
//            o_count              : occupancy 0..2
//  Notes   : push and pop in the same cycle are legal at any occupancy,
//            including FULL (head leaves, new entry lands at the tail).
//  Revision: 1.0  initial release
// ============================================================================
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [ENT_W-1:0] i_push_data,
   input  logic             i_pop,
   output logic [ENT_W-1:0] o_head,
   output logic [1:0]       o_count
);

   occ_e             r_occ;
   logic [ENT_W-1:0] r_mem0;   // head slot
   logic [ENT_W-1:0] r_mem1;   // tail slot when FULL

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_occ  <= OCC_EMPTY;
         r_mem0 <= '0;
         r_mem1 <= '0;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               // Nothing to pop; a push simply fills the head slot.
               if (i_push) begin
                  r_mem0 <= i_push_data;
                  r_occ  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (i_push && i_pop) begin
                  r_mem0 <= i_push_data;
               end else if (i_push) begin
                  r_mem1 <= i_push_data;
                  r_occ  <= OCC_FULL;
               end else if (i_pop) begin
                  r_occ  <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (i_pop) begin
                  r_mem0 <= r_mem1;
                  if (i_push) begin
                     r_mem1 <= i_push_data;
                  end else begin
                     r_occ  <= OCC_ONE;
                  end
               end
            end
            default: r_occ <= OCC_EMPTY;
         endcase
      end
   end

   assign o_head  = r_mem0;
   assign o_count = r_occ;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : wb_port_arbiter
//  Purpose : Shares the single register-file write port between the
//            pipeline WB stage and a multi-cycle unit (MDU). Pipeline writes
//            always win; MDU results bypass straight through when the port
//            and FIFO are free, otherwise wait in a 2-entry in-order FIFO.
//  Ports   : clk, rst (async active-low)
//            wb_wreg/wb_destR/wb_dest     : pipeline write request
//            mdu_valid/mdu_destR/mdu_data : MDU result offer
//            mdu_ready                    : FIFO has space (pend_cnt < 2)
//            rf_we/rf_waddr/rf_wdata      : register-file write port
//            src_sel                      : 0 pipeline, 1 MDU
//            stall_req                    : FIFO full or head waited too long
//            pend_cnt                     : buffered MDU results 0..2
//            conflict_cnt                 : (WB_ARB_STAT_EN only) saturating
//                                           count of pipeline/MDU conflicts
//  Config  : `define WB_ARB_STAT_EN to add the conflict_cnt statistic.
//  Revision: 1.0  initial release
// ============================================================================
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_wreg,
   input  logic [REG_W-1:0]  wb_destR,
   input  logic [DATA_W-1:0] wb_dest,
   input  logic              mdu_valid,
   input  logic [REG_W-1:0]  mdu_destR,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              src_sel,
   output logic              stall_req,
   output logic [1:0]        pend_cnt
`ifdef WB_ARB_STAT_EN
   ,
   output logic [15:0]       conflict_cnt
`endif
);

   localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

   logic             w_pipe_wr;
   logic             w_xfer;
   logic             w_xfer_keep;
   logic             w_fifo_ne;
   logic             w_pop;
   logic             w_bypass;
   logic             w_push;
   logic [ENT_W-1:0] w_head;
   logic [1:0]       w_count;
   logic [3:0]       r_wait;

   assign w_pipe_wr   = wb_wreg && (wb_destR != '0);
   assign mdu_ready   = (w_count != 2'd2);
   // MDU side is frozen while reset is asserted; the pipeline path is not.
   assign w_xfer      = rst && mdu_valid && mdu_ready;
   // Writes to r0 are accepted from the MDU but never reach the port.
   assign w_xfer_keep = w_xfer && (mdu_destR != '0);
   assign w_fifo_ne   = (w_count != 2'd0);
   assign w_pop       = rst && !w_pipe_wr && w_fifo_ne;
   assign w_bypass    = !w_pipe_wr && !w_fifo_ne && w_xfer_keep;
   assign w_push      = w_xfer_keep && !w_bypass;

   wb_result_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data ({mdu_destR, mdu_data}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count)
   );

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      src_sel  = SRC_PIPE;
      if (w_pipe_wr) begin
         rf_we    = 1'b1;
         rf_waddr = wb_destR;
         rf_wdata = wb_dest;
      end else if (w_pop) begin
         rf_we    = 1'b1;
         rf_waddr = w_head[ENT_W-1:DATA_W];
         rf_wdata = w_head[DATA_W-1:0];
         src_sel  = SRC_MDU;
      end else if (w_bypass) begin
         rf_we    = 1'b1;
         rf_waddr = mdu_destR;
         rf_wdata = mdu_data;
         src_sel  = SRC_MDU;
      end
   end

   // Age of the FIFO head in cycles spent blocked by pipeline writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait <= '0;
      end else if (!w_fifo_ne || w_pop) begin
         r_wait <= '0;
      end else if (r_wait != c_MAX_WAIT) begin
         r_wait <= r_wait + 4'd1;
      end
   end

   assign pend_cnt  = w_count;
   assign stall_req = (w_count == 2'd2) || (r_wait == c_MAX_WAIT);

`ifdef WB_ARB_STAT_EN
   logic [15:0] r_conflict;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_conflict <= '0;
      end else if (w_pipe_wr && (w_fifo_ne || w_xfer_keep) && (r_conflict != 16'hFFFF)) begin
         r_conflict <= r_conflict + 16'd1;
      end
   end

   assign conflict_cnt = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_wb_port_arbiter
//  Purpose : Self-checking bench for wb_port_arbiter: directed scenarios plus
//            randomized traffic compared against a queue-based reference.
//  Revision: 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_wreg = 1'b0;
   logic [4:0]  wb_destR = '0;
   logic [31:0] wb_dest = '0;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_destR = '0;
   logic [31:0] mdu_data = '0;
   logic        mdu_ready, rf_we, src_sel, stall_req;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  pend_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .wb_wreg   (wb_wreg),
      .wb_destR  (wb_destR),
      .wb_dest   (wb_dest),
      .mdu_valid (mdu_valid),
      .mdu_destR (mdu_destR),
      .mdu_data  (mdu_data),
      .mdu_ready (mdu_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .src_sel   (src_sel),
      .stall_req (stall_req),
      .pend_cnt  (pend_cnt)
   );

   // ---------------- reference model ----------------
   // Pending MDU results in acceptance order, and how many cycles the
   // oldest one has been held back while the queue was non-empty.
   logic [36:0] q[$];
   int          wcnt = 0;

   // Expected outputs packed as {we, waddr, wdata, src_sel, pend, ready, stall}
   function automatic logic [42:0] peek();
      logic        pipe, take, we, s;
      logic [4:0]  a;
      logic [31:0] d;
      pipe = wb_wreg && (wb_destR != 5'd0);
      take = rst_n && mdu_valid && (q.size() < 2) && (mdu_destR != 5'd0);
      we = 1'b0; a = '0; d = '0; s = 1'b0;
      if (pipe) begin
         we = 1'b1; a = wb_destR; d = wb_dest;
      end else if (q.size() > 0) begin
         we = 1'b1; a = q[0][36:32]; d = q[0][31:0]; s = 1'b1;
      end else if (take) begin
         we = 1'b1; a = mdu_destR; d = mdu_data; s = 1'b1;
      end
      return {we, a, d, s, 2'(q.size()), (q.size() < 2), (q.size() == 2) || (wcnt == MAX_WAIT)};
   endfunction

   function automatic logic [42:0] obs();
      return {rf_we, rf_waddr, rf_wdata, src_sel, pend_cnt, mdu_ready, stall_req};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         wcnt = 0;
      end else begin
         logic pipe, take, popped;
         pipe   = wb_wreg && (wb_destR != 5'd0);
         take   = mdu_valid && (q.size() < 2) && (mdu_destR != 5'd0);
         popped = !pipe && (q.size() > 0);
         if (q.size() > 0 && !popped) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
         else wcnt = 0;
         if (popped) void'(q.pop_front());
         // A result arriving at an idle port with an empty queue goes straight out.
         if (take && !(!pipe && q.size() == 0 && !popped)) q.push_back({mdu_destR, mdu_data});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                        input logic v, input logic [4:0] mr, input logic [31:0] md);
      @(negedge clk);
      wb_wreg = w; wb_destR = wr; wb_dest = wd;
      mdu_valid = v; mdu_destR = mr; mdu_data = md;
      #2;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // Pipeline write during reset must pass; MDU offer must be ignored.
      drive(1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 5'd4, 32'h44);
      checks++;
      if (obs() !== {1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL reset_pipe: got %h want %h", obs(), {1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 1'b0});
      end
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
      checks++;
      if (obs() !== 43'd0 + {1'b1, 1'b0}) begin
         errors++; $display("FAIL reset_idle: got %h want %h", obs(), 43'd0 + {1'b1, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_bypass();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
      checks++;
      if (obs() !== {1'b1, 5'd5, 32'h11, 1'b1, 2'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL bypass: got %h want %h", obs(), {1'b1, 5'd5, 32'h11, 1'b1, 2'd0, 1'b1, 1'b0});
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (pend_cnt !== 2'd0 || rf_we !== 1'b0) begin
         errors++; $display("FAIL bypass_after: got pend=%0d we=%b want pend=0 we=0", pend_cnt, rf_we);
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007);
      checks++;
      if (obs() !== {1'b1, 5'd3, 32'hAAAA0003, 1'b0, 2'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL collide_pipe: got %h want %h", obs(), {1'b1, 5'd3, 32'hAAAA0003, 1'b0, 2'd0, 1'b1, 1'b0});
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (obs() !== {1'b1, 5'd7, 32'hBBBB0007, 1'b1, 2'd1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL collide_mdu: got %h want %h", obs(), {1'b1, 5'd7, 32'hBBBB0007, 1'b1, 2'd1, 1'b1, 1'b0});
      end
   endtask

   task automatic test_fill();
      logic [31:0] d;
      // Pipeline busy for 3 cycles while three MDU results are offered.
      for (int i = 0; i < 3; i++) begin
         d = 32'hC0 + 32'(i);
         drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'(10 + i), d);
         checks++;
         if (obs() !== peek()) begin
            errors++; $display("FAIL fill_%0d: got %h want %h", i, obs(), peek());
         end
      end
      checks++;
      if (pend_cnt !== 2'd2 || mdu_ready !== 1'b0 || stall_req !== 1'b1) begin
         errors++; $display("FAIL fill_full: got pend=%0d rdy=%b stall=%b want 2 0 1", pend_cnt, mdu_ready, stall_req);
      end
      // Third result still offered while the queue drains.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 32'h0, (i < 2), 5'd12, 32'hC2);
         checks++;
         if (obs() !== peek()) begin
            errors++; $display("FAIL drain_%0d: got %h want %h", i, obs(), peek());
         end
      end
   endtask

   task automatic test_wait();
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h66);
      for (int i = 0; i < MAX_WAIT; i++) begin
         drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
         checks++;
         if (obs() !== peek()) begin
            errors++; $display("FAIL wait_%0d: got %h want %h", i, obs(), peek());
         end
      end
      drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0);
      checks++;
      if (stall_req !== 1'b1 || pend_cnt !== 2'd1) begin
         errors++; $display("FAIL wait_stall: got stall=%b pend=%0d want 1 1", stall_req, pend_cnt);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (rf_waddr !== 5'd6 || src_sel !== 1'b1) begin
         errors++; $display("FAIL wait_pop: got addr=%0d sel=%b want 6 1", rf_waddr, src_sel);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (stall_req !== 1'b0 || pend_cnt !== 2'd0) begin
         errors++; $display("FAIL wait_clear: got stall=%b pend=%0d want 0 0", stall_req, pend_cnt);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h21);
      @(negedge clk);
      wb_wreg = 1'b0; mdu_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      checks++;
      if (pend_cnt !== 2'd0 || mdu_ready !== 1'b1 || stall_req !== 1'b0) begin
         errors++; $display("FAIL rstmid: got pend=%0d rdy=%b stall=%b want 0 1 0", pend_cnt, mdu_ready, stall_req);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         checks++;
         if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_stale_%0d: got we=%b want 0", i, rf_we);
         end
      end
   endtask

   task automatic test_zero_dest();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h88);
      drive(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0);
      checks++;
      if (obs() !== {1'b1, 5'd8, 32'h88, 1'b1, 2'd1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL zero_pipe: got %h want %h", obs(), {1'b1, 5'd8, 32'h88, 1'b1, 2'd1, 1'b1, 1'b0});
      end
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
      checks++;
      if (rf_we !== 1'b0 || pend_cnt !== 2'd0) begin
         errors++; $display("FAIL zero_mdu: got we=%b pend=%0d want 0 0", rf_we, pend_cnt);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (rf_we !== 1'b0 || pend_cnt !== 2'd0) begin
         errors++; $display("FAIL zero_after: got we=%b pend=%0d want 0 0", rf_we, pend_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rst_n     = ($urandom_range(0, 79) != 0);
         wb_wreg   = ($urandom_range(0, 99) < 55);
         wb_destR  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wb_dest   = $urandom;
         mdu_valid = ($urandom_range(0, 99) < 45);
         mdu_destR = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         mdu_data  = $urandom;
         #2;
         checks++;
         if (obs() !== peek()) begin
            errors++; $display("FAIL random_%0d: got %h want %h", i, obs(), peek());
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_collision();
      test_fill();
      test_wait();
      test_reset_mid();
      test_zero_dest();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
